// File: rtl/muldiv_pkg.sv
// Shared types and op-decode helpers for the iterative
// RV32M multiply/divide unit.
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } muldiv_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } muldiv_state_e;

  function automatic logic is_div(muldiv_op_e op);
    return op[2];
  endfunction

  function automatic logic is_quot(muldiv_op_e op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic is_signed_a(muldiv_op_e op);
    return (op == OP_MULH) || (op == OP_MULHSU) ||
           (op == OP_DIV)  || (op == OP_REM);
  endfunction

  function automatic logic is_signed_b(muldiv_op_e op);
    return (op == OP_MULH) || (op == OP_DIV) ||
           (op == OP_REM);
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// Core-side request/response bundle of the muldiv unit.
// The core drives the request, the unit answers with stall/done.
interface muldiv_if #(
  parameter int XLEN = 32
) ();
  import muldiv_pkg::*;

  logic            start_i;
  muldiv_op_e      op_i;
  logic            abort_i;
  logic [XLEN-1:0] rs1_i;
  logic [XLEN-1:0] rs2_i;
  logic            stall_o;
  logic            done_o;
  logic [XLEN-1:0] result_o;

  modport master (
    output start_i, op_i, abort_i, rs1_i, rs2_i,
    input  stall_o, done_o, result_o
  );

  modport slave (
    input  start_i, op_i, abort_i, rs1_i, rs2_i,
    output stall_o, done_o, result_o
  );

endinterface

// File: rtl/muldiv_iter.sv
// One combinational step: shift-add multiply or
// restoring-divide, on acc = {hi, lo} and a fixed operand.
module muldiv_iter #(
  parameter int XLEN = 32
) (
  input  logic              div_i,
  input  logic [2*XLEN-1:0] acc_i,
  input  logic [XLEN-1:0]   opnd_i,
  output logic [2*XLEN-1:0] acc_o,
  output logic [XLEN-1:0]   opnd_o
);

  logic [XLEN:0] sum;
  logic [XLEN:0] cand;
  logic [XLEN:0] diff;

  always_comb begin
    sum    = {1'b0, acc_i[2*XLEN-1:XLEN]} +
             (acc_i[0] ? {1'b0, opnd_i} : '0);
    cand   = acc_i[2*XLEN-1:XLEN-1];
    diff   = cand - {1'b0, opnd_i};
    acc_o  = '0;
    opnd_o = opnd_i;
    if (div_i) begin
      // lo half shifts in quotient bits, hi half is remainder
      if (diff[XLEN])
        acc_o = {cand[XLEN-1:0], acc_i[XLEN-2:0], 1'b0};
      else
        acc_o = {diff[XLEN-1:0], acc_i[XLEN-2:0], 1'b1};
    end else begin
      acc_o = {sum, acc_i[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: XLEN steps per op,
// stalls the core until the one-cycle done pulse.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int CNTW = $clog2(XLEN) + 1
) (
  input  logic    clk_i,
  input  logic    rst_i,
  muldiv_if.slave bus
);

  localparam logic [XLEN-1:0] MIN_NEG =
    {1'b1, {(XLEN-1){1'b0}}};

  muldiv_state_e     state_q, state_d;
  muldiv_op_e        op_q, op_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic              neg_q, neg_d;
  logic              negr_q, negr_d;
  logic [XLEN-1:0]   result_q, result_d;

  logic              sa, sb, div0, ovf;
  logic [XLEN-1:0]   abs_a, abs_b, spec_res;
  logic [2*XLEN-1:0] acc_nx, prod;
  logic [XLEN-1:0]   opnd_nx, quo, rem, fin_res;

  muldiv_iter #(.XLEN(XLEN)) u_iter (
    .div_i  (is_div(op_q)),
    .acc_i  (acc_q),
    .opnd_i (opnd_q),
    .acc_o  (acc_nx),
    .opnd_o (opnd_nx)
  );

  always_comb begin
    sa    = is_signed_a(bus.op_i) & bus.rs1_i[XLEN-1];
    sb    = is_signed_b(bus.op_i) & bus.rs2_i[XLEN-1];
    abs_a = sa ? -bus.rs1_i : bus.rs1_i;
    abs_b = sb ? -bus.rs2_i : bus.rs2_i;
    div0  = is_div(bus.op_i) && (bus.rs2_i == '0);
    ovf   = ((bus.op_i == OP_DIV) ||
             (bus.op_i == OP_REM)) &&
            (bus.rs1_i == MIN_NEG) && (bus.rs2_i == '1);
    // overflow quotient equals the dividend itself
    if (div0)
      spec_res = is_quot(bus.op_i) ? '1 : bus.rs1_i;
    else
      spec_res = is_quot(bus.op_i) ? bus.rs1_i : '0;
  end

  always_comb begin
    prod    = neg_q ? -acc_nx : acc_nx;
    quo     = acc_nx[XLEN-1:0];
    rem     = acc_nx[2*XLEN-1:XLEN];
    fin_res = '0;
    unique case (1'b1)
      (op_q == OP_MUL):
        fin_res = prod[XLEN-1:0];
      (!is_div(op_q) && op_q != OP_MUL):
        fin_res = prod[2*XLEN-1:XLEN];
      is_quot(op_q):
        fin_res = neg_q ? -quo : quo;
      (is_div(op_q) && !is_quot(op_q)):
        fin_res = negr_q ? -rem : rem;
      default:
        fin_res = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    negr_d   = negr_q;
    result_d = result_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start_i) begin
          op_d  = bus.op_i;
          cnt_d = '0;
          if (div0 || ovf) begin
            result_d = spec_res;
            state_d  = S_DONE;
          end else begin
            acc_d   = {{XLEN{1'b0}}, abs_a};
            opnd_d  = abs_b;
            neg_d   = sa ^ sb;
            negr_d  = sa;
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        acc_d  = acc_nx;
        opnd_d = opnd_nx;
        cnt_d  = cnt_q + CNTW'(1);
        if (cnt_q == CNTW'(XLEN-1)) begin
          result_d = fin_res;
          state_d  = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (bus.abort_i) begin
      state_d  = S_IDLE;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      op_q     <= OP_MUL;
      acc_q    <= '0;
      opnd_q   <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      negr_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      negr_q   <= negr_d;
      result_q <= result_d;
    end
  end

  assign bus.stall_o  = (state_q == S_IDLE && bus.start_i &&
                         !bus.abort_i) || (state_q == S_CALC);
  assign bus.done_o   = (state_q == S_DONE);
  assign bus.result_o = result_q;

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide execution unit, placed beside the ALU.
- Consumes the register-file read ports (rs1/rs2 data) and produces write-back data for the register-file write port.
- Holds the core via a stall output while it iterates, and releases it for exactly one cycle when the result is valid for write-back.
- One operation in flight at a time; all eight M-extension ops supported.

Parameters:
- XLEN, 32, operand/result width; iteration count equals XLEN.
- CNTW, $clog2(XLEN)+1, iteration counter width.

Ports:
- clk_i  input  1  core clock; all state updates on posedge.
- rst_i  input  1  reset, asynchronous, active-high.
- start_i  input  1  decoded M-extension instruction present; sampled only in IDLE.
- op_i  input  3  funct3 encoding: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- abort_i  input  1  synchronous cancel (trap/flush); returns the unit to IDLE.
- rs1_i  input  XLEN  operand A (rdata1).
- rs2_i  input  XLEN  operand B (rdata2).
- stall_o  output  1  freeze PC and register-file write enable while high.
- done_o  output  1  one-cycle pulse; result_o is valid for write-back this cycle.
- result_o  output  XLEN  operation result; holds its value until the next completion.

Behaviour:
- Reset (async): state=IDLE; done_o=0; result_o=0; counter=0; all internal operand/accumulator registers=0.
- States: IDLE, CALC, DONE.
- IDLE -> CALC on start_i. At that edge, latch op, absolute values of the operands (per op signedness), and result-sign flags; counter=0.
- IDLE -> DONE directly, with result written at that same edge, for the special cases:
  - divisor==0: DIV/DIVU give all-ones; REM/REMU give rs1.
  - DIV/REM with rs1=0x80000000 and rs2=0xFFFFFFFF: quotient 0x80000000, remainder 0.
- CALC:
  - One iteration per cycle; counter increments.
  - After iteration XLEN (counter==XLEN-1), apply sign fixup, write result_o, go to DONE.
- DONE: done_o=1 for exactly one cycle, then IDLE unconditionally.
- Latency: start_i high in cycle 0 -> done_o high in cycle XLEN+1 (33) normally, or cycle 1 for the special cases.
- stall_o is combinational: (IDLE && start_i && !abort_i) || CALC. It is low in DONE, so the instruction retires and writes result_o that cycle.
- start_i in CALC or DONE is ignored. The core holds the instruction stable while stalled; after DONE, the next start_i is accepted only in IDLE.
- abort_i has priority over start_i and over CALC progression. Any state -> IDLE; done_o not asserted; result_o unchanged.
- Multiply algorithm:
  - Shift-add on magnitudes into a 2*XLEN accumulator.
  - Product negated (two's complement, 2*XLEN wide) when the operand signs differ.
  - Signedness: MULH signed×signed; MULHSU rs1 signed, rs2 unsigned; MULHU and MUL unsigned magnitudes (MUL is sign-agnostic).
  - MUL returns bits [XLEN-1:0]; MULH/MULHSU/MULHU return bits [2XLEN-1:XLEN].
- Divide algorithm:
  - Restoring division on magnitudes.
  - Quotient negated when the signs differ (signed ops).
  - Remainder takes the sign of the dividend (signed ops).
- All arithmetic is modulo 2^XLEN on results. No exceptions are raised.
- Reset mid-CALC: immediate IDLE; stall_o drops combinationally; done_o stays low.

Decomposition:
- Package muldiv_pkg:
  - typedef enum logic [2:0] muldiv_op_e (the eight ops, funct3 values).
  - typedef enum logic [1:0] muldiv_state_e (IDLE, CALC, DONE).
  - Helper functions is_div(op) and is_signed_a/b(op).
- One sub-module, muldiv_iter:
  - Purely combinational single-step datapath.
  - Inputs: op class, accumulator, operand register.
  - Outputs: next accumulator, next operand register.
  - Serves as either a shift-add step or a restoring-subtract step.
- FSM, counter, latching and sign fixup stay in muldiv_unit.

Test Plan:
- MUL rs1=7, rs2=0xFFFFFFFD -> stall_o high cycles 0–32; done_o=1 only in cycle 33; result_o=0xFFFFFFEB.
- Multiply-high ops:
  - MULH 0x80000000×0x80000000 -> 0x40000000.
  - MULHU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFF.
- Divide/remainder:
  - DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD.
  - REM -7 % 2 -> 0xFFFFFFFF.
  - DIVU 0xFFFFFFF9 / 2 -> 0x7FFFFFFC.
- Special cases:
  - DIVU 5/0 -> done_o in cycle 1, 0xFFFFFFFF.
  - REMU 5/0 -> 5.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000.
  - REM of the same operands -> 0.
- Interruptions:
  - rst_i asserted in cycle 10 of a DIV -> stall_o=0, done_o=0, result_o=0 immediately.
  - abort_i in cycle 10 -> IDLE, result_o unchanged.
  - A fresh MUL 3×4 afterwards -> 12 at cycle 33.
- start_i held high with a changed op_i during CALC -> ignored; the original op completes with the original result; a new start is accepted only after DONE.
